// File: rtl/robo_pkg.sv
// ============================================================================
// robo_pkg
// Shared types and constants for the wall-following robot controller.
// Revision: 1.0
// ============================================================================
`default_nettype none

package robo_pkg;

  // Controller run phases
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SENSE = 2'd1,
    ST_ISSUE = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  // Reason the last run ended
  localparam logic [1:0] STOP_NONE  = 2'd0;
  localparam logic [1:0] STOP_LIMIT = 2'd1;
  localparam logic [1:0] STOP_STUCK = 2'd2;
  localparam logic [1:0] STOP_ABORT = 2'd3;

  // Action kinds offered to the world-model memory
  typedef enum logic [1:0] {
    ACT_NONE   = 2'd0,
    ACT_FWD    = 2'd1,
    ACT_TURN   = 2'd2,
    ACT_REMOVE = 2'd3
  } action_e;

  // Rotation direction and removal target encodings
  localparam logic DIR_LEFT  = 1'b0;
  localparam logic DIR_RIGHT = 1'b1;
  localparam logic REM_UNDER = 1'b0;
  localparam logic REM_AHEAD = 1'b1;

endpackage

`default_nettype wire

// File: rtl/robo_decide.sv
// ============================================================================
// robo_decide
// Combinational wall-follower decision: picks one action from the sensor
// snapshot, the followed side and whether the robot already turned toward it.
// Revision: 1.0
// ============================================================================
`default_nettype none

module robo_decide
  import robo_pkg::*;
(
  input  logic    i_head,
  input  logic    i_side,
  input  logic    i_under,
  input  logic    i_barrier,
  input  logic    i_mode,
  input  logic    i_turned,
  output action_e o_action,
  output logic    o_dir,
  output logic    o_rem_ahead,
  output logic    o_turned
);

  // Priority chain: trash first, then hug the wall, then advance, clear, or turn away
  always_comb begin
    o_action    = ACT_NONE;
    o_dir       = DIR_LEFT;
    o_rem_ahead = REM_UNDER;
    o_turned    = i_turned;
    if (i_under) begin
      o_action = ACT_REMOVE;
    end else if (!i_side && !i_turned) begin
      // Only one turn toward an open side until the robot moves again
      o_action = ACT_TURN;
      o_dir    = i_mode;
      o_turned = 1'b1;
    end else if (!i_head) begin
      o_action = ACT_FWD;
      o_turned = 1'b0;
    end else if (i_barrier) begin
      o_action    = ACT_REMOVE;
      o_rem_ahead = REM_AHEAD;
    end else begin
      o_action = ACT_TURN;
      o_dir    = ~i_mode;
    end
  end

endmodule

`default_nettype wire

// File: rtl/robo_ctrl.sv
// ============================================================================
// robo_ctrl
// Wall-following robot controller: run FSM, action handshake with the
// world-model memory, step budget, stuck detection, abort and counters.
// Revision: 1.0
// ============================================================================
`default_nettype none

module robo_ctrl
  import robo_pkg::*;
#(
  parameter int STEP_W    = 16,
  parameter int TRASH_W   = 8,
  parameter int MAX_TURNS = 4
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               start,
  input  logic               abort,
  input  logic               mode,
  input  logic [STEP_W-1:0]  step_limit,
  input  logic               sens_valid,
  input  logic               head,
  input  logic               side,
  input  logic               under,
  input  logic               barrier,
  output logic               act_valid,
  input  logic               act_ready,
  output logic               avancar,
  output logic               girar,
  output logic               girar_dir,
  output logic               remover,
  output logic               rem_ahead,
  output logic               busy,
  output logic               done,
  output logic [1:0]         stop_cause,
  output logic [STEP_W-1:0]  steps,
  output logic [TRASH_W-1:0] trash_cnt
);

  localparam int              TC_W        = $clog2(MAX_TURNS + 1);
  localparam logic [TC_W-1:0] C_MAX_TURNS = TC_W'(MAX_TURNS);

  state_e              r_state,    w_state;
  logic                r_mode,     w_mode;
  logic [STEP_W-1:0]   r_limit,    w_limit;
  logic                r_turned,   w_turned;
  logic [TC_W-1:0]     r_turn_cnt, w_turn_cnt;
  logic [STEP_W-1:0]   r_steps,    w_steps;
  logic [TRASH_W-1:0]  r_trash,    w_trash;
  logic [1:0]          r_cause,    w_cause;
  logic                r_avancar,  w_avancar;
  logic                r_girar,    w_girar;
  logic                r_dir,      w_dir;
  logic                r_remover,  w_remover;
  logic                r_rem_ahead, w_rem_ahead;
  logic                r_act_valid;
  logic                r_busy;
  logic                r_done;

  logic [STEP_W-1:0]   w_steps_inc;
  logic [TC_W-1:0]     w_turns_inc;
  logic                w_accept;
  action_e             w_dec_action;
  logic                w_dec_dir;
  logic                w_dec_rem_ahead;
  logic                w_dec_turned;

  assign w_accept = r_act_valid & act_ready;

  robo_decide u_decide (
    .i_head      (head),
    .i_side      (side),
    .i_under     (under),
    .i_barrier   (barrier),
    .i_mode      (r_mode),
    .i_turned    (r_turned),
    .o_action    (w_dec_action),
    .o_dir       (w_dec_dir),
    .o_rem_ahead (w_dec_rem_ahead),
    .o_turned    (w_dec_turned)
  );

  // Next-state, counter and action-line computation
  always_comb begin
    w_state     = r_state;
    w_mode      = r_mode;
    w_limit     = r_limit;
    w_turned    = r_turned;
    w_turn_cnt  = r_turn_cnt;
    w_steps     = r_steps;
    w_trash     = r_trash;
    w_cause     = r_cause;
    w_avancar   = r_avancar;
    w_girar     = r_girar;
    w_dir       = r_dir;
    w_remover   = r_remover;
    w_rem_ahead = r_rem_ahead;
    w_steps_inc = r_steps + STEP_W'(1);
    w_turns_inc = r_turn_cnt + TC_W'(1);
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_state    = ST_SENSE;
          w_mode     = mode;
          w_limit    = step_limit;
          w_steps    = '0;
          w_trash    = '0;
          w_cause    = STOP_NONE;
          w_turned   = 1'b0;
          w_turn_cnt = '0;
        end
      end
      ST_SENSE: begin
        if (abort) begin
          w_state = ST_DONE;
          w_cause = STOP_ABORT;
        end else if (sens_valid) begin
          w_state     = ST_ISSUE;
          w_avancar   = (w_dec_action == ACT_FWD);
          w_girar     = (w_dec_action == ACT_TURN);
          w_remover   = (w_dec_action == ACT_REMOVE);
          w_dir       = w_dec_dir;
          w_rem_ahead = w_dec_rem_ahead;
          w_turned    = w_dec_turned;
        end
      end
      ST_ISSUE: begin
        if (w_accept) begin
          w_state = ST_SENSE;
          if (r_avancar) begin
            w_steps    = w_steps_inc;
            w_turn_cnt = '0;
            if ((r_limit != '0) && (w_steps_inc == r_limit)) begin
              w_state = ST_DONE;
              w_cause = STOP_LIMIT;
            end
          end else if (r_girar) begin
            w_turn_cnt = w_turns_inc;
            if (w_turns_inc == C_MAX_TURNS) begin
              w_state = ST_DONE;
              w_cause = STOP_STUCK;
            end
          end else if (r_remover && !r_rem_ahead && (r_trash != {TRASH_W{1'b1}})) begin
            w_trash = r_trash + TRASH_W'(1);
          end
          // The accepted action still counts, but abort names the cause
          if (abort) begin
            w_state = ST_DONE;
            w_cause = STOP_ABORT;
          end
        end else if (abort) begin
          w_state = ST_DONE;
          w_cause = STOP_ABORT;
        end
      end
      ST_DONE: begin
        w_state = ST_IDLE;
      end
      default: begin
        w_state = ST_IDLE;
      end
    endcase
    // Action lines are only meaningful while an action is offered
    if (w_state != ST_ISSUE) begin
      w_avancar   = 1'b0;
      w_girar     = 1'b0;
      w_remover   = 1'b0;
      w_dir       = 1'b0;
      w_rem_ahead = 1'b0;
    end
  end

  // State and registered-output update
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state     <= ST_IDLE;
      r_mode      <= 1'b0;
      r_limit     <= '0;
      r_turned    <= 1'b0;
      r_turn_cnt  <= '0;
      r_steps     <= '0;
      r_trash     <= '0;
      r_cause     <= STOP_NONE;
      r_avancar   <= 1'b0;
      r_girar     <= 1'b0;
      r_dir       <= 1'b0;
      r_remover   <= 1'b0;
      r_rem_ahead <= 1'b0;
      r_act_valid <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_state     <= w_state;
      r_mode      <= w_mode;
      r_limit     <= w_limit;
      r_turned    <= w_turned;
      r_turn_cnt  <= w_turn_cnt;
      r_steps     <= w_steps;
      r_trash     <= w_trash;
      r_cause     <= w_cause;
      r_avancar   <= w_avancar;
      r_girar     <= w_girar;
      r_dir       <= w_dir;
      r_remover   <= w_remover;
      r_rem_ahead <= w_rem_ahead;
      r_act_valid <= (w_state == ST_ISSUE);
      r_busy      <= (w_state != ST_IDLE);
      r_done      <= (w_state == ST_DONE);
    end
  end

  assign act_valid  = r_act_valid;
  assign avancar    = r_avancar;
  assign girar      = r_girar;
  assign girar_dir  = r_dir;
  assign remover    = r_remover;
  assign rem_ahead  = r_rem_ahead;
  assign busy       = r_busy;
  assign done       = r_done;
  assign stop_cause = r_cause;
  assign steps      = r_steps;
  assign trash_cnt  = r_trash;

endmodule

`default_nettype wire

// File: tb/tb_robo_ctrl.sv
// ============================================================================
// tb_robo_ctrl
// Self-checking bench for robo_ctrl: decision table, directed multi-cycle
// sequences and randomized runs against a transaction-level reference model.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_robo_ctrl;

  localparam int STEP_W    = 16;
  localparam int TRASH_W   = 8;
  localparam int MAX_TURNS = 4;
  localparam int TRASH_MAX = (1 << TRASH_W) - 1;

  localparam int A_NONE = 0;
  localparam int A_FWD  = 1;
  localparam int A_TURN = 2;
  localparam int A_REM  = 3;

  logic               clock = 1'b0;
  logic               reset = 1'b0;
  logic               start = 1'b0;
  logic               abort = 1'b0;
  logic               mode = 1'b0;
  logic [STEP_W-1:0]  step_limit = '0;
  logic               sens_valid = 1'b0;
  logic               head = 1'b0;
  logic               side = 1'b0;
  logic               under = 1'b0;
  logic               barrier = 1'b0;
  logic               act_ready = 1'b0;
  logic               act_valid;
  logic               avancar;
  logic               girar;
  logic               girar_dir;
  logic               remover;
  logic               rem_ahead;
  logic               busy;
  logic               done;
  logic [1:0]         stop_cause;
  logic [STEP_W-1:0]  steps;
  logic [TRASH_W-1:0] trash_cnt;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state
  logic              m_mode;
  logic [STEP_W-1:0] m_limit;
  logic [STEP_W-1:0] m_steps;
  int                m_trash;
  int                m_turns;
  logic              m_turned;

  typedef struct {
    int   act;
    logic dir;
    logic ra;
    logic turned;
  } dec_t;

  typedef struct {
    logic md, h, s, u, b;
    int   act;
    logic dir;
    logic ra;
  } vec_t;

  vec_t vt[9];

  robo_ctrl #(
    .STEP_W    (STEP_W),
    .TRASH_W   (TRASH_W),
    .MAX_TURNS (MAX_TURNS)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .start      (start),
    .abort      (abort),
    .mode       (mode),
    .step_limit (step_limit),
    .sens_valid (sens_valid),
    .head       (head),
    .side       (side),
    .under      (under),
    .barrier    (barrier),
    .act_valid  (act_valid),
    .act_ready  (act_ready),
    .avancar    (avancar),
    .girar      (girar),
    .girar_dir  (girar_dir),
    .remover    (remover),
    .rem_ahead  (rem_ahead),
    .busy       (busy),
    .done       (done),
    .stop_cause (stop_cause),
    .steps      (steps),
    .trash_cnt  (trash_cnt)
  );

  always #5 clock = ~clock;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, got, exp, $time);
    end
  endtask

  // Wall-follower rules in priority order
  function automatic dec_t ref_decide(input logic md, input logic h, input logic s,
                                      input logic u, input logic b, input logic t);
    dec_t d;
    d.act = A_NONE; d.dir = 1'b0; d.ra = 1'b0; d.turned = t;
    if (u) d.act = A_REM;
    else if (!s && !t) begin d.act = A_TURN; d.dir = md; d.turned = 1'b1; end
    else if (!h) begin d.act = A_FWD; d.turned = 1'b0; end
    else if (b) begin d.act = A_REM; d.ra = 1'b1; end
    else begin d.act = A_TURN; d.dir = ~md; end
    return d;
  endfunction

  task automatic chk_lines(input string tag, input dec_t d);
    chk({tag, "_act_valid"}, 32'(act_valid), 32'd1);
    chk({tag, "_avancar"}, 32'(avancar), 32'(d.act == A_FWD));
    chk({tag, "_girar"}, 32'(girar), 32'(d.act == A_TURN));
    chk({tag, "_remover"}, 32'(remover), 32'(d.act == A_REM));
    if (d.act == A_TURN) chk({tag, "_girar_dir"}, 32'(girar_dir), 32'(d.dir));
    if (d.act == A_REM)  chk({tag, "_rem_ahead"}, 32'(rem_ahead), 32'(d.ra));
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_act_valid"}, 32'(act_valid), 32'd0);
    chk({tag, "_lines"}, 32'({avancar, girar, girar_dir, remover, rem_ahead}), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_stop_cause"}, 32'(stop_cause), 32'd0);
    chk({tag, "_steps"}, 32'(steps), 32'd0);
    chk({tag, "_trash"}, 32'(trash_cnt), 32'd0);
  endtask

  task automatic start_run(input logic md, input logic [STEP_W-1:0] lim);
    chk("start_idle", 32'(busy), 32'd0);
    mode = md; step_limit = lim; start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    mode = 1'($urandom); step_limit = STEP_W'($urandom);
    m_mode = md; m_limit = lim; m_steps = '0; m_trash = 0; m_turns = 0; m_turned = 1'b0;
    chk("start_busy", 32'(busy), 32'd1);
    chk("start_cause", 32'(stop_cause), 32'd0);
    chk("start_steps", 32'(steps), 32'd0);
    chk("start_trash", 32'(trash_cnt), 32'd0);
    chk("start_act_valid", 32'(act_valid), 32'd0);
  endtask

  // After an end-of-run cycle: done pulse observed, then back to idle
  task automatic chk_end(input logic [1:0] cause);
    chk("end_done", 32'(done), 32'd1);
    chk("end_busy", 32'(busy), 32'd1);
    chk("end_act_valid", 32'(act_valid), 32'd0);
    chk("end_cause", 32'(stop_cause), 32'(cause));
    @(negedge clock);
    chk("idle_done", 32'(done), 32'd0);
    chk("idle_busy", 32'(busy), 32'd0);
    chk("idle_cause_held", 32'(stop_cause), 32'(cause));
    chk("idle_steps_held", 32'(steps), 32'(m_steps));
  endtask

  task automatic abort_sense();
    abort = 1'b1;
    @(negedge clock);
    abort = 1'b0;
    chk("abort_steps", 32'(steps), 32'(m_steps));
    chk_end(2'd3);
  endtask

  // One full sensor->action transaction, checked against the model
  task automatic do_action(input logic h, input logic s, input logic u, input logic b,
                           input int sv_dly, input int rdy_dly, input bit ab_acc,
                           output bit ended);
    dec_t d;
    int   cause;
    for (int i = 0; i < sv_dly; i++) begin
      sens_valid = 1'b0;
      start = 1'($urandom);
      @(negedge clock);
      start = 1'b0;
      chk("sense_wait_valid", 32'(act_valid), 32'd0);
      chk("sense_wait_busy", 32'(busy), 32'd1);
    end
    head = h; side = s; under = u; barrier = b; sens_valid = 1'b1;
    d = ref_decide(m_mode, h, s, u, b, m_turned);
    @(negedge clock);
    sens_valid = 1'b0;
    head = 1'($urandom); side = 1'($urandom); under = 1'($urandom); barrier = 1'($urandom);
    chk_lines("offer", d);
    for (int i = 0; i < rdy_dly; i++) begin
      act_ready = 1'b0;
      @(negedge clock);
      chk_lines("stall", d);
    end
    act_ready = 1'b1; abort = ab_acc;
    @(negedge clock);
    act_ready = 1'b0; abort = 1'b0;
    m_turned = d.turned;
    cause = 0;
    if (d.act == A_FWD) begin
      m_steps = m_steps + 1'b1;
      m_turns = 0;
      if (m_limit != 0 && m_steps == m_limit) cause = 1;
    end else if (d.act == A_TURN) begin
      m_turns++;
      if (m_turns == MAX_TURNS) cause = 2;
    end else if (d.act == A_REM && !d.ra) begin
      if (m_trash < TRASH_MAX) m_trash++;
    end
    if (ab_acc) cause = 3;
    chk("acc_steps", 32'(steps), 32'(m_steps));
    chk("acc_trash", 32'(trash_cnt), 32'(m_trash));
    if (cause != 0) begin
      chk_end(2'(cause));
      ended = 1'b1;
    end else begin
      chk("acc_done", 32'(done), 32'd0);
      chk("acc_busy", 32'(busy), 32'd1);
      chk("acc_act_valid", 32'(act_valid), 32'd0);
      ended = 1'b0;
    end
  endtask

  initial begin
    bit ended;
    dec_t d;

    vt[0] = '{md:0, h:0, s:1, u:0, b:0, act:A_FWD,  dir:0, ra:0};
    vt[1] = '{md:0, h:0, s:0, u:0, b:0, act:A_TURN, dir:0, ra:0};
    vt[2] = '{md:1, h:0, s:0, u:0, b:0, act:A_TURN, dir:1, ra:0};
    vt[3] = '{md:0, h:1, s:1, u:1, b:1, act:A_REM,  dir:0, ra:0};
    vt[4] = '{md:1, h:1, s:1, u:0, b:1, act:A_REM,  dir:0, ra:1};
    vt[5] = '{md:1, h:1, s:1, u:0, b:0, act:A_TURN, dir:0, ra:0};
    vt[6] = '{md:0, h:1, s:1, u:0, b:0, act:A_TURN, dir:1, ra:0};
    vt[7] = '{md:1, h:0, s:1, u:0, b:1, act:A_FWD,  dir:0, ra:0};
    vt[8] = '{md:0, h:1, s:0, u:0, b:1, act:A_TURN, dir:0, ra:0};

    // Reset state
    repeat (3) @(negedge clock);
    chk_all_zero("reset");
    reset = 1'b1;
    @(negedge clock);
    chk_all_zero("post_reset");

    // Decision table: each vector in a fresh run, then aborted while stalled
    for (int i = 0; i < 9; i++) begin
      start_run(vt[i].md, '0);
      head = vt[i].h; side = vt[i].s; under = vt[i].u; barrier = vt[i].b;
      sens_valid = 1'b1;
      @(negedge clock);
      sens_valid = 1'b0;
      d.act = vt[i].act; d.dir = vt[i].dir; d.ra = vt[i].ra; d.turned = 1'b0;
      chk_lines($sformatf("vec%0d", i), d);
      abort = 1'b1;
      @(negedge clock);
      abort = 1'b0;
      chk_end(2'd3);
    end

    // Step limit of 3
    start_run(1'b0, 16'd3);
    for (int i = 0; i < 3; i++) do_action(1'b0, 1'b1, 1'b0, 1'b0, 0, 0, 1'b0, ended);
    chk("limit_ended", 32'(ended), 32'd1);
    chk("limit_steps", 32'(steps), 32'd3);

    // Turn toward open side once, then advance
    start_run(1'b1, '0);
    do_action(1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 1'b0, ended);
    do_action(1'b0, 1'b0, 1'b0, 1'b0, 1, 1, 1'b0, ended);
    abort_sense();

    // Boxed in: MAX_TURNS turns away from the wall declare stuck
    start_run(1'b0, '0);
    for (int i = 0; i < MAX_TURNS; i++) do_action(1'b1, 1'b1, 1'b0, 1'b0, 0, 0, 1'b0, ended);
    chk("stuck_ended", 32'(ended), 32'd1);
    chk("stuck_steps", 32'(steps), 32'd0);

    // Trash counter saturation, then barrier removal
    start_run(1'b0, '0);
    for (int i = 0; i < 300; i++)
      do_action(1'($urandom), 1'($urandom), 1'b1, 1'($urandom), 0, 0, 1'b0, ended);
    chk("trash_sat", 32'(trash_cnt), 32'(TRASH_MAX));
    do_action(1'b1, 1'b1, 1'b0, 1'b1, 0, 0, 1'b0, ended);
    abort_sense();

    // Five-cycle stall, then abort coinciding with acceptance
    start_run(1'b1, '0);
    do_action(1'b0, 1'b1, 1'b0, 1'b0, 0, 5, 1'b1, ended);
    chk("abort_acc_steps", 32'(steps), 32'd1);

    // Asynchronous reset while an action is offered
    start_run(1'b0, '0);
    do_action(1'b0, 1'b1, 1'b0, 1'b0, 0, 0, 1'b0, ended);
    head = 1'b0; side = 1'b1; under = 1'b0; sens_valid = 1'b1;
    @(negedge clock);
    sens_valid = 1'b0;
    chk("pre_reset_valid", 32'(act_valid), 32'd1);
    reset = 1'b0;
    #1;
    chk_all_zero("async_reset");
    @(negedge clock);
    reset = 1'b1;
    act_ready = 1'b1;
    sens_valid = 1'b1;
    repeat (3) @(negedge clock);
    act_ready = 1'b0;
    sens_valid = 1'b0;
    chk("no_resume_busy", 32'(busy), 32'd0);
    chk("no_resume_valid", 32'(act_valid), 32'd0);

    // Randomized runs
    for (int r = 0; r < 25; r++) begin
      start_run(1'($urandom), STEP_W'($urandom_range(0, 6)));
      ended = 1'b0;
      for (int k = 0; k < 40 && !ended; k++) begin
        int sel;
        sel = $urandom_range(0, 29);
        if (sel == 0) begin
          abort_sense();
          ended = 1'b1;
        end else begin
          do_action(1'($urandom), 1'($urandom), ($urandom_range(0, 3) == 0), 1'($urandom),
                    $urandom_range(0, 2), $urandom_range(0, 2), (sel == 1), ended);
        end
      end
      if (!ended) abort_sense();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
